// File: rtl/ex_stage_pkg.sv
// Shared CPU parameters: one-hot instruction-type bit indices, reset PC and Tnew encodings.
package cpu_param;

  localparam int INSTR_W = 60;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  localparam int I_ADDU = 0;
  localparam int I_SUBU = 1;
  localparam int I_ORI  = 2;
  localparam int I_LW   = 3;
  localparam int I_SW   = 4;
  localparam int I_BEQ  = 5;
  localparam int I_LUI  = 6;
  localparam int I_J    = 7;
  localparam int I_JAL  = 8;
  localparam int I_JR   = 9;
  localparam int I_SLL  = 10;

  // A bubble is encoded as sll $0,$0,0.
  localparam logic [INSTR_W-1:0] ITYPE_NOP = INSTR_W'(1) << I_SLL;

  localparam logic [2:0] TNEW_NOW = 3'd0;
  localparam logic [2:0] TNEW_ALU = 3'd1;
  localparam logic [2:0] TNEW_LW  = 3'd2;

  function automatic logic [2:0] age_tnew(input logic [2:0] t);
    return (t == TNEW_NOW) ? TNEW_NOW : t - 3'd1;
  endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational result select for the execute stage, keyed by the one-hot instruction type.
module alu
  import cpu_param::*;
#(
  parameter int INSTR_W = 60
) (
  input  logic [31:0]        i_a,
  input  logic [31:0]        i_b,
  input  logic [31:0]        i_imm32,
  input  logic [INSTR_W-1:0] i_itype,
  input  logic [31:0]        i_lui_res,
  input  logic [31:0]        i_pc,
  output logic [31:0]        o_result
);

  // Only a handful of type bits select a result; the rest are don't-care here.
  logic w_unused_itype;
  assign w_unused_itype = ^i_itype;

  always_comb begin
    o_result = 32'h0;
    if (i_itype[I_ADDU])
      o_result = i_a + i_b;
    else if (i_itype[I_SUBU])
      o_result = i_a - i_b;
    else if (i_itype[I_ORI])
      o_result = i_a | i_imm32;
    else if (i_itype[I_LW] || i_itype[I_SW])
      o_result = i_a + i_imm32;
    else if (i_itype[I_SLL])
      o_result = i_b << i_a[4:0];
    else if (i_itype[I_LUI])
      o_result = i_lui_res;
    else if (i_itype[I_JAL])
      o_result = i_pc + 32'd8;
  end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: operand forwarding from MEM/WB, ALU, Tnew aging and the EX/MEM register.
module ex_stage
  import cpu_param::*;
#(
  parameter int          INSTR_W  = 60,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         raddr0_id_ex,
  input  logic [4:0]         raddr1_id_ex,
  input  logic [4:0]         waddr_id_ex,
  input  logic [31:0]        imm32_id_ex,
  input  logic [INSTR_W-1:0] itype_id_ex,
  input  logic [31:0]        rdata0_id_ex,
  input  logic [31:0]        rdata1_id_ex,
  input  logic [31:0]        lui_res_id_ex,
  input  logic [31:0]        pc_id_ex,
  input  logic [2:0]         tnew_id_ex,
  input  logic [4:0]         mem_fwd_addr,
  input  logic [31:0]        mem_fwd_data,
  input  logic               mem_fwd_ok,
  input  logic [4:0]         wb_fwd_addr,
  input  logic [31:0]        wb_fwd_data,
  input  logic               wb_fwd_we,
  output logic [4:0]         raddr1_ex_mem,
  output logic [4:0]         waddr_ex_mem,
  output logic [31:0]        result_ex_mem,
  output logic [31:0]        store_data_ex_mem,
  output logic [INSTR_W-1:0] itype_ex_mem,
  output logic [31:0]        pc_ex_mem,
  output logic [2:0]         tnew_ex_mem
);

  localparam logic [INSTR_W-1:0] NOP_V = {{(INSTR_W-1){1'b0}}, 1'b1} << I_SLL;

  logic [31:0] w_opa, w_opb, w_result;

  function automatic logic [31:0] fwd_sel(input logic [4:0] ra, input logic [31:0] rd,
                                          input logic [4:0] ma, input logic [31:0] md,
                                          input logic mok, input logic [4:0] wa,
                                          input logic [31:0] wd, input logic wwe);
    if (ra != 5'd0 && ra == ma && mok) return md;
    else if (ra != 5'd0 && ra == wa && wwe) return wd;
    else return rd;
  endfunction

  // For sll the rs slot carries shamt, not a register value, so it must bypass forwarding.
  always_comb begin
    w_opa = rdata0_id_ex;
    if (!itype_id_ex[I_SLL])
      w_opa = fwd_sel(raddr0_id_ex, rdata0_id_ex, mem_fwd_addr, mem_fwd_data, mem_fwd_ok,
                      wb_fwd_addr, wb_fwd_data, wb_fwd_we);
    w_opb = fwd_sel(raddr1_id_ex, rdata1_id_ex, mem_fwd_addr, mem_fwd_data, mem_fwd_ok,
                    wb_fwd_addr, wb_fwd_data, wb_fwd_we);
  end

  alu #(.INSTR_W(INSTR_W)) u_alu (
    .i_a       (w_opa),
    .i_b       (w_opb),
    .i_imm32   (imm32_id_ex),
    .i_itype   (itype_id_ex),
    .i_lui_res (lui_res_id_ex),
    .i_pc      (pc_id_ex),
    .o_result  (w_result)
  );

  // EX/MEM pipeline register
  always_ff @(posedge clk) begin
    if (reset) begin
      raddr1_ex_mem     <= 5'd0;
      waddr_ex_mem      <= 5'd0;
      result_ex_mem     <= 32'h0;
      store_data_ex_mem <= 32'h0;
      itype_ex_mem      <= NOP_V;
      pc_ex_mem         <= RESET_PC;
      tnew_ex_mem       <= TNEW_NOW;
    end else begin
      raddr1_ex_mem     <= raddr1_id_ex;
      waddr_ex_mem      <= waddr_id_ex;
      result_ex_mem     <= w_result;
      store_data_ex_mem <= w_opb;
      itype_ex_mem      <= itype_id_ex;
      pc_ex_mem         <= pc_id_ex;
      tnew_ex_mem       <= age_tnew(tnew_id_ex);
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed table-driven bench for ex_stage plus reset and back-to-back forwarding sequences.
module tb_ex_stage;
  import cpu_param::*;

  localparam int W = 60;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    raddr0_id_ex, raddr1_id_ex, waddr_id_ex;
  logic [31:0]   imm32_id_ex, rdata0_id_ex, rdata1_id_ex, lui_res_id_ex, pc_id_ex;
  logic [W-1:0]  itype_id_ex;
  logic [2:0]    tnew_id_ex;
  logic [4:0]    mem_fwd_addr, wb_fwd_addr;
  logic [31:0]   mem_fwd_data, wb_fwd_data;
  logic          mem_fwd_ok, wb_fwd_we;
  logic [4:0]    raddr1_ex_mem, waddr_ex_mem;
  logic [31:0]   result_ex_mem, store_data_ex_mem, pc_ex_mem;
  logic [W-1:0]  itype_ex_mem;
  logic [2:0]    tnew_ex_mem;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_stage #(.INSTR_W(W), .RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .reset(reset),
    .raddr0_id_ex(raddr0_id_ex), .raddr1_id_ex(raddr1_id_ex), .waddr_id_ex(waddr_id_ex),
    .imm32_id_ex(imm32_id_ex), .itype_id_ex(itype_id_ex), .rdata0_id_ex(rdata0_id_ex),
    .rdata1_id_ex(rdata1_id_ex), .lui_res_id_ex(lui_res_id_ex), .pc_id_ex(pc_id_ex),
    .tnew_id_ex(tnew_id_ex),
    .mem_fwd_addr(mem_fwd_addr), .mem_fwd_data(mem_fwd_data), .mem_fwd_ok(mem_fwd_ok),
    .wb_fwd_addr(wb_fwd_addr), .wb_fwd_data(wb_fwd_data), .wb_fwd_we(wb_fwd_we),
    .raddr1_ex_mem(raddr1_ex_mem), .waddr_ex_mem(waddr_ex_mem), .result_ex_mem(result_ex_mem),
    .store_data_ex_mem(store_data_ex_mem), .itype_ex_mem(itype_ex_mem),
    .pc_ex_mem(pc_ex_mem), .tnew_ex_mem(tnew_ex_mem)
  );

  typedef struct {
    string        name;
    logic [W-1:0] itype;
    logic [4:0]   ra0, ra1, wa;
    logic [31:0]  rd0, rd1, imm, lui, pc;
    logic [2:0]   tnew;
    logic [4:0]   mfa;
    logic [31:0]  mfd;
    logic         mok;
    logic [4:0]   wfa;
    logic [31:0]  wfd;
    logic         wwe;
    logic [31:0]  exp_res, exp_st;
    logic [2:0]   exp_tnew;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [W-1:0] oh(input int idx);
    logic [W-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic vec_t mk(input string n, input int it, input logic [4:0] ra0,
                              input logic [31:0] rd0, input logic [4:0] ra1,
                              input logic [31:0] rd1, input logic [4:0] wa,
                              input logic [31:0] imm, input logic [31:0] pc,
                              input logic [2:0] tnew, input logic [4:0] mfa,
                              input logic [31:0] mfd, input logic mok,
                              input logic [4:0] wfa, input logic [31:0] wfd, input logic wwe,
                              input logic [31:0] er, input logic [31:0] es,
                              input logic [2:0] et);
    vec_t v;
    v.name = n; v.itype = oh(it); v.ra0 = ra0; v.rd0 = rd0; v.ra1 = ra1; v.rd1 = rd1;
    v.wa = wa; v.imm = imm; v.lui = 32'h1234_0000; v.pc = pc; v.tnew = tnew;
    v.mfa = mfa; v.mfd = mfd; v.mok = mok; v.wfa = wfa; v.wfd = wfd; v.wwe = wwe;
    v.exp_res = er; v.exp_st = es; v.exp_tnew = et;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    itype_id_ex = v.itype; raddr0_id_ex = v.ra0; raddr1_id_ex = v.ra1; waddr_id_ex = v.wa;
    rdata0_id_ex = v.rd0; rdata1_id_ex = v.rd1; imm32_id_ex = v.imm; lui_res_id_ex = v.lui;
    pc_id_ex = v.pc; tnew_id_ex = v.tnew;
    mem_fwd_addr = v.mfa; mem_fwd_data = v.mfd; mem_fwd_ok = v.mok;
    wb_fwd_addr = v.wfa; wb_fwd_data = v.wfd; wb_fwd_we = v.wwe;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".raddr1"}, 64'(raddr1_ex_mem), 64'd0);
    chk({tag, ".waddr"}, 64'(waddr_ex_mem), 64'd0);
    chk({tag, ".result"}, 64'(result_ex_mem), 64'd0);
    chk({tag, ".store"}, 64'(store_data_ex_mem), 64'd0);
    chk({tag, ".itype"}, 64'(itype_ex_mem), 64'(oh(I_SLL)));
    chk({tag, ".pc"}, 64'(pc_ex_mem), 64'h3000);
    chk({tag, ".tnew"}, 64'(tnew_ex_mem), 64'd0);
  endtask

  vec_t junk;

  initial begin
    //             name        type    ra0 rd0           ra1 rd1          wa  imm        pc          tn mfa mfd        mok wfa wfd        we  exp_res       exp_st       et
    vecs.push_back(mk("addu_mem", I_ADDU, 8, 32'h1,       9, 32'h2,        10, 32'h0,     32'h3000, 1, 8, 32'h10,    1,  0, 32'h0,     0, 32'h12,       32'h2,       0));
    vecs.push_back(mk("ori_prio", I_ORI,  5, 32'h0,       0, 32'h0,        11, 32'hF,     32'h3004, 1, 5, 32'hAAAA,  1,  5, 32'hBBBB,  1, 32'hAAAF,     32'h0,       0));
    vecs.push_back(mk("ori_r0",   I_ORI,  0, 32'h0,       0, 32'h0,        11, 32'hF,     32'h3008, 1, 0, 32'hAAAA,  1,  0, 32'hBBBB,  1, 32'hF,        32'h0,       0));
    vecs.push_back(mk("sll_shamt",I_SLL,  2, 32'h4,       3, 32'h1,        12, 32'h0,     32'h300C, 1, 0, 32'h0,     0,  2, 32'h1,     1, 32'h10,       32'h1,       0));
    vecs.push_back(mk("jal",      I_JAL,  0, 32'h0,       0, 32'h0,        31, 32'h0,     32'h3004, 0, 0, 32'h0,     0,  0, 32'h0,     0, 32'h300C,     32'h0,       0));
    vecs.push_back(mk("lw",       I_LW,   4, 32'h100,     0, 32'h0,        13, 32'h20,    32'h3010, 2, 0, 32'h0,     0,  0, 32'h0,     0, 32'h120,      32'h0,       1));
    vecs.push_back(mk("sw_wb",    I_SW,   1, 32'h40,      7, 32'h0,        0,  32'h4,     32'h3014, 0, 0, 32'h0,     0,  7, 32'hDEAD,  1, 32'h44,       32'hDEAD,    0));
    vecs.push_back(mk("subu_nok", I_SUBU, 3, 32'h5,       4, 32'h7,        14, 32'h0,     32'h3018, 1, 3, 32'h99,    0,  3, 32'hA,     1, 32'h3,        32'h7,       0));
    vecs.push_back(mk("addu_wrap",I_ADDU, 0, 32'hFFFFFFFF,6, 32'h0,        15, 32'h0,     32'h301C, 1, 6, 32'h2,     1,  6, 32'h5,     1, 32'h1,        32'h2,       0));
    vecs.push_back(mk("lui",      I_LUI,  0, 32'h0,       0, 32'h0,        16, 32'h0,     32'h3020, 0, 0, 32'h0,     0,  0, 32'h0,     0, 32'h12340000, 32'h0,       0));
    vecs.push_back(mk("beq",      I_BEQ,  1, 32'h5,       2, 32'h5,        0,  32'h8,     32'h3024, 0, 0, 32'h0,     0,  0, 32'h0,     0, 32'h0,        32'h5,       0));
    vecs.push_back(mk("jr",       I_JR,   31,32'h4000,    0, 32'h0,        0,  32'h0,     32'h3028, 0, 0, 32'h0,     0,  0, 32'h0,     0, 32'h0,        32'h0,       0));
    vecs.push_back(mk("j",        I_J,    0, 32'h0,       0, 32'h0,        0,  32'h3,     32'h302C, 0, 0, 32'h0,     0,  0, 32'h0,     0, 32'h0,        32'h0,       0));
    vecs.push_back(mk("wb_we0",   I_ADDU, 2, 32'h3,       0, 32'h4,        17, 32'h0,     32'h3030, 1, 0, 32'h0,     0,  2, 32'h64,    0, 32'h7,        32'h4,       0));
    vecs.push_back(mk("wb_r0",    I_ADDU, 0, 32'h1,       0, 32'h9,        18, 32'h0,     32'h3034, 1, 0, 32'h0,     1,  0, 32'h32,    1, 32'hA,        32'h9,       0));
    vecs.push_back(mk("bubble",   I_SLL,  0, 32'h0,       0, 32'h0,        0,  32'h0,     32'h3038, 0, 0, 32'h0,     0,  0, 32'h0,     0, 32'h0,        32'h0,       0));

    // Reset for two cycles with arbitrary instruction inputs present.
    junk = mk("junk", I_ADDU, 8, 32'h55, 9, 32'h66, 20, 32'h77, 32'h8888, 2, 8, 32'h1, 1, 9, 32'h2, 1, 0, 0, 0);
    reset = 1'b1;
    drive(junk);
    repeat (2) @(posedge clk);
    #1 chk_reset("reset");

    @(negedge clk);
    reset = 1'b0;
    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      chk({vecs[i].name, ".result"}, 64'(result_ex_mem), 64'(vecs[i].exp_res));
      chk({vecs[i].name, ".store"}, 64'(store_data_ex_mem), 64'(vecs[i].exp_st));
      chk({vecs[i].name, ".tnew"}, 64'(tnew_ex_mem), 64'(vecs[i].exp_tnew));
      chk({vecs[i].name, ".waddr"}, 64'(waddr_ex_mem), 64'(vecs[i].wa));
      chk({vecs[i].name, ".raddr1"}, 64'(raddr1_ex_mem), 64'(vecs[i].ra1));
      chk({vecs[i].name, ".itype"}, 64'(itype_ex_mem), 64'(vecs[i].itype));
      chk({vecs[i].name, ".pc"}, 64'(pc_ex_mem), 64'(vecs[i].pc));
      @(negedge clk);
    end

    // Back-to-back: producer addu r10 = 3 + 4, consumer addu r11 = r10 + 1 with stale rs.
    drive(mk("prod", I_ADDU, 1, 32'h3, 2, 32'h4, 10, 32'h0, 32'h3100, TNEW_ALU, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1 chk("b2b.prod", 64'(result_ex_mem), 64'h7);
    @(negedge clk);
    drive(mk("cons", I_ADDU, 10, 32'h0, 0, 32'h1, 11, 32'h0, 32'h3104, TNEW_ALU, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    mem_fwd_addr = waddr_ex_mem;
    mem_fwd_data = result_ex_mem;
    mem_fwd_ok   = (tnew_ex_mem == 3'd0);
    @(posedge clk);
    #1 chk("b2b.cons", 64'(result_ex_mem), 64'h8);

    // Reset asserted mid-stream discards the instruction present that cycle.
    @(negedge clk);
    drive(vecs[0]);
    reset = 1'b1;
    @(posedge clk);
    #1 chk_reset("midreset");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1 chk("post_reset.result", 64'(result_ex_mem), 64'h12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
